voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Note-event front end that drives the note_on/note_off side of NUM_VOICES envelope generators and consumes their busy/done returns.
- Accepts note-on/note-off events over a valid/ready interface and assigns each note-on to a free voice.
- Steals the oldest held voice when all voices are occupied.
- Publishes the note number per voice so the oscillator bank can follow.

Parameters:
- NUM_VOICES, 4, number of envelope generator voices driven.
- NOTE_W, 7, note number width.
- AGE_W, 4, width of the saturating per-voice age counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted when ev_valid & ev_ready.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_W  note number.
- voice_note_on  out  NUM_VOICES  one-cycle note_on pulse per voice.
- voice_note_off  out  NUM_VOICES  one-cycle note_off pulse per voice.
- voice_busy  in  NUM_VOICES  envelope busy per voice.
- voice_done  in  NUM_VOICES  envelope release-complete pulse per voice.
- voice_note  out  NUM_VOICES*NOTE_W  note assigned to each voice; voice i occupies bits [i*NOTE_W +: NOTE_W].
- voice_held  out  NUM_VOICES  voice is in HELD state.

Behaviour:
- Reset: all outputs 0 except ev_ready=1; every voice FREE, ages 0, voice_note 0.
- Per-voice states:
  - FREE -> ARMED on allocation; note_on pulse is issued in that cycle.
  - ARMED -> HELD on the first cycle voice_busy=1.
  - HELD -> RELEASING on note_off pulse.
  - RELEASING -> FREE on voice_done.
- A FREE voice is allocatable only while voice_busy=0. This covers a reset while the envelopes are still running.
- Event FSM states: IDLE, ALLOC, OFF_WAIT, STEAL_WAIT. ev_ready=1 only in IDLE, so throughput is one event per 2 cycles minimum.
- Note-on accepted at cycle T:
  - If a FREE and non-busy voice exists, the lowest index wins.
  - The voice's note_on pulse, voice_note write and state change happen at T+1.
  - The allocated voice's age goes to 0; every other non-FREE voice's age increments, saturating at 2^AGE_W-1.
- Note-on when no voice is free:
  - With a HELD voice available: pick the oldest HELD voice (max age, ties to lowest index), pulse its note_off at T+1, then enter STEAL_WAIT.
  - When that voice's done arrives, issue note_on to it on the next cycle.
  - If only ARMED or RELEASING voices exist: wait in STEAL_WAIT for any voice_done (lowest index if several arrive together) and allocate that voice.
- Note-on for a note already ARMED or HELD: accepted and dropped, no pulses.
- Note-off:
  - Match on the lowest-index ARMED or HELD voice with an equal note.
  - If the match is HELD: note_off pulse at T+1.
  - If the match is ARMED: hold in OFF_WAIT until busy is seen, then pulse. This guarantees the generator has left IDLE before it sees note_off.
  - No match: event dropped.
- Pulses are never asserted on a FREE voice.
- note_on and note_off are never asserted in the same cycle.
- voice_done on a voice that is not RELEASING is ignored.
- Reset mid-steal abandons the pending event.

Optional Feature:
- Macro: SUSTAIN_PEDAL_EN.
- When defined:
  - Adds input sustain_pedal (1 bit).
  - A note-off matching a HELD voice while sustain_pedal=1 marks the voice SUSTAINED; no pulse is issued.
  - On the sustain_pedal falling edge, every SUSTAINED voice gets note_off, one voice per cycle in ascending index. ev_ready is low until the pedal flush is complete.
  - SUSTAINED voices are eligible for stealing; ties go to the oldest.
- When undefined: no port, no SUSTAINED state, note-off always pulses.

Decomposition:
- Package voice_alloc_pkg holds:
  - voice state enum: FREE, ARMED, HELD, RELEASING, SUSTAINED.
  - event FSM enum.
  - default NOTE_W.
- One sub-module, oldest_voice_picker: combinational; takes the held mask and ages, returns the oldest index and a valid flag.

Test Plan (NUM_VOICES=4):
- Reset, busy=0, note-on 60 at T -> voice_note_on=4'b0001 at T+1, voice_note[6:0]=60; busy=1 -> voice_held[0]=1.
- Note-on 60 then note-off 60 issued back-to-back before busy rises -> note_off pulse delayed until 1 cycle after busy[0]=1; never during ARMED.
- Note-ons 60, 62, 64, 65 all held, then note-on 67 -> note_off on voice 0; after done[0] pulse, note_on on voice 0 next cycle, voice_note=67; ev_ready low throughout.
- All four voices RELEASING, note-on 70, done[2] and done[3] pulse together -> voice 2 allocated.
- Note-off 50 (unheld) and duplicate note-on 60 -> accepted in 1 cycle, no pulses.
- SUSTAIN_PEDAL_EN, pedal=1, note-off 60 and 62 -> no pulses; pedal falls -> note_off on voice 0 then voice 1 on consecutive cycles.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : voice_alloc_pkg                                              |
// | Description : Shared types for the voice allocator. Holds the per-voice    |
// |               state enum, the event FSM enum and the default note width.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package voice_alloc_pkg;

    localparam int DEFAULT_NOTE_W = 7;

    typedef enum logic [2:0] {
        V_FREE      = 3'd0,
        V_ARMED     = 3'd1,
        V_HELD      = 3'd2,
        V_RELEASING = 3'd3,
        V_SUSTAINED = 3'd4
    } voice_state_e;

    typedef enum logic [1:0] {
        EV_IDLE       = 2'd0,
        EV_ALLOC      = 2'd1,
        EV_OFF_WAIT   = 2'd2,
        EV_STEAL_WAIT = 2'd3
    } ev_state_e;

endpackage
`default_nettype wire

// File: rtl/oldest_voice_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : oldest_voice_picker                                          |
// | Description : Combinational search for the oldest candidate voice.         |
// |               Ties resolve to the lowest index.                            |
// | Ports       : cand_mask    - voices eligible for selection                 |
// |               ages         - packed per-voice ages, voice i at [i*AGE_W+:] |
// |               oldest_idx   - index of the oldest candidate                 |
// |               oldest_valid - at least one candidate exists                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module oldest_voice_picker #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_VOICES-1:0]       cand_mask,
    input  logic [NUM_VOICES*AGE_W-1:0] ages,
    output logic [IDX_W-1:0]            oldest_idx,
    output logic                        oldest_valid
);

    logic [AGE_W-1:0] w_best_age;

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        oldest_idx   = '0;
        oldest_valid = 1'b0;
        w_best_age   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (cand_mask[i] && (!oldest_valid || (ages[i*AGE_W +: AGE_W] > w_best_age))) begin
                oldest_idx   = IDX_W'(i);
                oldest_valid = 1'b1;
                w_best_age   = ages[i*AGE_W +: AGE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : voice_allocator                                              |
// | Description : Note-event front end for NUM_VOICES envelope generators.     |
// |               Allocates note-ons to free voices, steals the oldest held    |
// |               voice when full, routes note-offs and publishes notes.       |
// | Ports       : ev_valid/ev_ready/ev_on/ev_note - event handshake            |
// |               voice_note_on/voice_note_off    - one-cycle pulses per voice |
// |               voice_busy/voice_done           - envelope returns           |
// |               voice_note                      - packed note per voice      |
// |               voice_held                      - voice in HELD state        |
// |               sustain_pedal (SUSTAIN_PEDAL_EN only)                        |
// | Options     : define SUSTAIN_PEDAL_EN for sustain pedal support            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = DEFAULT_NOTE_W,
    parameter int AGE_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    output logic [NUM_VOICES-1:0]        voice_note_on,
    output logic [NUM_VOICES-1:0]        voice_note_off,
    input  logic [NUM_VOICES-1:0]        voice_busy,
    input  logic [NUM_VOICES-1:0]        voice_done,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_held
`ifdef SUSTAIN_PEDAL_EN
    ,
    input  logic                         sustain_pedal
`endif
);

    localparam int               c_IDX_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] c_AGE_MAX = '1;

    // ---------------------------------------------------------------- state
    ev_state_e             ev_state_q, ev_state_d;
    voice_state_e          vstate_q [NUM_VOICES];
    voice_state_e          vstate_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q    [NUM_VOICES];
    logic [AGE_W-1:0]      age_d    [NUM_VOICES];
    logic [NOTE_W-1:0]     note_q   [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d   [NUM_VOICES];
    logic [NUM_VOICES-1:0] note_on_q, note_on_d;
    logic [NUM_VOICES-1:0] note_off_q, note_off_d;
    logic [NOTE_W-1:0]     pend_note_q, pend_note_d;
    logic [c_IDX_W-1:0]    tgt_q, tgt_d;
    logic                  tgt_valid_q, tgt_valid_d;

    // ---------------------------------------------------------------- wires
    logic [NUM_VOICES-1:0]       w_free_m, w_held_m, w_rel_m, w_sus_m, w_match_m, w_done_m;
    logic [NUM_VOICES*AGE_W-1:0] w_ages_flat;
    logic [c_IDX_W-1:0]          w_pick_idx;
    logic                        w_pick_valid;
    logic                        w_alloc_en, w_off_en, w_off_sus;
    logic [c_IDX_W-1:0]          w_alloc_idx, w_off_idx;
    logic [NOTE_W-1:0]           w_alloc_note;
    logic                        w_pedal, w_flush_act;

    function automatic logic [c_IDX_W-1:0] lowest_idx(input logic [NUM_VOICES-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = c_IDX_W'(i);
        end
    endfunction

    // ---------------------------------------------------------- sustain pedal
`ifdef SUSTAIN_PEDAL_EN
    logic                  pedal_q;
    logic                  flush_q, flush_d;
    logic [NUM_VOICES-1:0] w_flush_off_m;

    assign w_pedal     = sustain_pedal;
    // Falling edge starts the flush; flush_q keeps it going one voice per cycle.
    assign w_flush_act = (pedal_q & ~sustain_pedal) | flush_q;
    assign flush_d     = w_flush_act & (|(w_sus_m & ~w_flush_off_m));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pedal_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            pedal_q <= sustain_pedal;
            flush_q <= flush_d;
        end
    end
`else
    assign w_pedal     = 1'b0;
    assign w_flush_act = 1'b0;
`endif

    // ---------------------------------------------------------- voice masks
    always_comb begin
        w_free_m    = '0;
        w_held_m    = '0;
        w_rel_m     = '0;
        w_sus_m     = '0;
        w_match_m   = '0;
        w_ages_flat = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            // A FREE voice whose envelope still runs (e.g. after reset) is not usable.
            w_free_m[i]  = (vstate_q[i] == V_FREE) && !voice_busy[i];
            w_held_m[i]  = (vstate_q[i] == V_HELD);
            w_rel_m[i]   = (vstate_q[i] == V_RELEASING);
            w_sus_m[i]   = (vstate_q[i] == V_SUSTAINED);
            w_match_m[i] = ((vstate_q[i] == V_ARMED) || (vstate_q[i] == V_HELD))
                           && (note_q[i] == ev_note);
            w_ages_flat[i*AGE_W +: AGE_W] = age_q[i];
        end
    end

    oldest_voice_picker #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (c_IDX_W)
    ) u_picker (
        .cand_mask    (w_held_m | w_sus_m),
        .ages         (w_ages_flat),
        .oldest_idx   (w_pick_idx),
        .oldest_valid (w_pick_valid)
    );

    assign ev_ready = (ev_state_q == EV_IDLE) && !w_flush_act;

    // ------------------------------------------------------- next state
    always_comb begin
        ev_state_d   = ev_state_q;
        vstate_d     = vstate_q;
        age_d        = age_q;
        note_d       = note_q;
        note_on_d    = '0;
        note_off_d   = '0;
        pend_note_d  = pend_note_q;
        tgt_d        = tgt_q;
        tgt_valid_d  = tgt_valid_q;
        w_alloc_en   = 1'b0;
        w_alloc_idx  = '0;
        w_alloc_note = pend_note_q;
        w_off_en     = 1'b0;
        w_off_idx    = '0;
        w_off_sus    = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        w_flush_off_m = '0;
`endif
        // In a targeted steal only the victim's done may complete the wait.
        w_done_m = voice_done & w_rel_m &
                   (tgt_valid_q ? (NUM_VOICES'(1) << tgt_q) : {NUM_VOICES{1'b1}});

        // Autonomous per-voice progress; event actions below take priority.
        for (int i = 0; i < NUM_VOICES; i++) begin
            if ((vstate_q[i] == V_ARMED) && voice_busy[i]) begin
                vstate_d[i] = V_HELD;
            end else if ((vstate_q[i] == V_RELEASING) && voice_done[i]) begin
                vstate_d[i] = V_FREE;
            end
        end

        case (ev_state_q)
            EV_IDLE: begin
                if (ev_valid && ev_ready) begin
                    ev_state_d = EV_ALLOC;
                    if (ev_on) begin
                        if (|w_match_m) begin
                            // duplicate note: dropped
                        end else if (|w_free_m) begin
                            w_alloc_en   = 1'b1;
                            w_alloc_idx  = lowest_idx(w_free_m);
                            w_alloc_note = ev_note;
                        end else begin
                            pend_note_d = ev_note;
                            tgt_valid_d = w_pick_valid;
                            tgt_d       = w_pick_idx;
                            ev_state_d  = EV_STEAL_WAIT;
                            if (w_pick_valid) begin
                                w_off_en  = 1'b1;
                                w_off_idx = w_pick_idx;
                            end
                        end
                    end else if (|w_match_m) begin
                        if (w_held_m[lowest_idx(w_match_m)]) begin
                            w_off_en  = 1'b1;
                            w_off_idx = lowest_idx(w_match_m);
                            w_off_sus = w_pedal;
                        end else begin
                            // Generator not yet out of IDLE: defer until busy.
                            tgt_d      = lowest_idx(w_match_m);
                            ev_state_d = EV_OFF_WAIT;
                        end
                    end
                end else if (w_flush_act && (|w_sus_m)) begin
                    w_off_en  = 1'b1;
                    w_off_idx = lowest_idx(w_sus_m);
`ifdef SUSTAIN_PEDAL_EN
                    w_flush_off_m = NUM_VOICES'(1) << lowest_idx(w_sus_m);
`endif
                end
            end
            EV_ALLOC: begin
                ev_state_d = EV_IDLE;
            end
            EV_OFF_WAIT: begin
                if (voice_busy[tgt_q]) begin
                    w_off_en   = 1'b1;
                    w_off_idx  = tgt_q;
                    w_off_sus  = w_pedal;
                    ev_state_d = EV_ALLOC;
                end
            end
            EV_STEAL_WAIT: begin
                if (|w_done_m) begin
                    w_alloc_en   = 1'b1;
                    w_alloc_idx  = lowest_idx(w_done_m);
                    w_alloc_note = pend_note_q;
                    ev_state_d   = EV_ALLOC;
                end
            end
            default: begin
                ev_state_d = EV_IDLE;
            end
        endcase

        if (w_off_en) begin
            if (w_off_sus) begin
                vstate_d[w_off_idx] = V_SUSTAINED;
            end else begin
                vstate_d[w_off_idx]   = V_RELEASING;
                note_off_d[w_off_idx] = 1'b1;
            end
        end

        if (w_alloc_en) begin
            vstate_d[w_alloc_idx]  = V_ARMED;
            note_d[w_alloc_idx]    = w_alloc_note;
            note_on_d[w_alloc_idx] = 1'b1;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (i == int'(w_alloc_idx)) begin
                    age_d[i] = '0;
                end else if ((vstate_q[i] != V_FREE) && (age_q[i] != c_AGE_MAX)) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_state_q  <= EV_IDLE;
            note_on_q   <= '0;
            note_off_q  <= '0;
            pend_note_q <= '0;
            tgt_q       <= '0;
            tgt_valid_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_q[i] <= V_FREE;
                age_q[i]    <= '0;
                note_q[i]   <= '0;
            end
        end else begin
            ev_state_q  <= ev_state_d;
            note_on_q   <= note_on_d;
            note_off_q  <= note_off_d;
            pend_note_q <= pend_note_d;
            tgt_q       <= tgt_d;
            tgt_valid_q <= tgt_valid_d;
            vstate_q    <= vstate_d;
            age_q       <= age_d;
            note_q      <= note_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign voice_note_on  = note_on_q;
    assign voice_note_off = note_off_q;

    always_comb begin
        voice_note = '0;
        voice_held = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
            voice_held[i]                  = (vstate_q[i] == V_HELD);
        end
    end

endmodule
`default_nettype wire
